sweep_result_reader: RTL and testbench
======================================

SWEEP_RESULT_READER -- requirements
Module: sweep_result_reader

Interface
REQ-001 SHALL have parameter N_POINTS, default 33: number of table entries, indices 0..N_POINTS-1.
REQ-002 SHALL have ports `clk` (in, 1) as the single clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have `rst` (in, 1): asynchronous, active-high reset.
REQ-004 SHALL have `start` (in, 1): begin a read-out pass; sampled only in IDLE.
REQ-005 SHALL have `raddr` (out, 8): read address to the sweep table.
REQ-006 SHALL have `amp_in` (in, 12, Q12.0): table amplitude at `raddr`, valid in the same cycle (combinational table read).
REQ-007 SHALL have `phase_in` (in, 12, Q3.9 signed, [-pi, pi]): table phase at `raddr`, valid in the same cycle.
REQ-008 SHALL have `tx_valid` (out, 1) and `tx_ready` (in, 1): valid/ready handshake on the entry stream.
REQ-009 SHALL have `tx_index` (out, 8), `tx_amp` (out, 12) and `tx_phase` (out, 12): the streamed entry.
REQ-010 SHALL have `busy` (out, 1): high in every state except IDLE.
REQ-011 SHALL have `done` (out, 1): one-cycle completion pulse.
REQ-012 SHALL have `peak_amp` (out, 12) and `peak_idx` (out, 8): the maximum amplitude and its index.
REQ-013 SHALL have `cut_lo_idx` and `cut_hi_idx` (out, 8 each), with `cut_lo_found` and `cut_hi_found` (out, 1 each): the -3 dB points.

Function
REQ-014 SHALL implement states IDLE, SCAN, LOAD, SEND, DONE.
REQ-015 IDLE: `start`=1 SHALL clear the peak and cutoff registers, set `raddr`=0 and go to SCAN; otherwise it SHALL stay in IDLE.
REQ-016 SCAN: each cycle SHALL compare `amp_in` with the running peak.
  - Strictly greater: update the peak (so ties keep the lowest index).
  - Then increment `raddr`.
  - After index N_POINTS-1 (exactly N_POINTS cycles): set `raddr`=0 and go to LOAD.
REQ-017 At SCAN exit SHALL register thr = (peak_amp*181)>>8: 20-bit product truncated to 12 bits, approximately 0.707*peak.
REQ-018 LOAD: SHALL register `amp_in`, `phase_in` and `raddr` into the `tx_*` outputs, set `tx_valid`=1 and go to SEND.
REQ-019 SEND: `tx_valid` and all `tx_*` SHALL hold stable until `tx_ready`=1; the handshake completes in that cycle.
REQ-020 On handshake with index i, if tx_amp < thr:
  - i < peak_idx: `cut_lo_idx`<=i and `cut_lo_found`<=1 (last such index wins).
  - i > peak_idx and `cut_hi_found`=0: `cut_hi_idx`<=i and `cut_hi_found`<=1 (first such index wins).
REQ-021 On handshake SHALL drop `tx_valid`. If i = N_POINTS-1, go to DONE; else increment `raddr` and go to LOAD. This gives one bubble cycle per entry, so the minimum is 2 cycles per entry.
REQ-022 DONE: SHALL assert `done` for exactly one cycle and go to IDLE.
REQ-023 `start` while `busy`=1 SHALL be ignored.
REQ-024 `peak_*`, `cut_*` and `tx_*` SHALL hold their values in IDLE until the next accepted `start`.
REQ-025 An all-zero table SHALL give `peak_amp`=0, `peak_idx`=0, thr=0 and no cutoff found.
REQ-026 `tx_ready` held high continuously SHALL give a total latency from `start` to `done` of 1+N_POINTS+2*N_POINTS+1 cycles.

Reset
REQ-027 `rst`=1 SHALL immediately force:
  - state IDLE;
  - `raddr`, `tx_*`, `peak_*`, `cut_*` and thr all to 0;
  - `tx_valid`, `busy`, `done` and both found flags to 0.
REQ-028 `rst` asserted mid-pass SHALL abort the pass with no `done` pulse; the next pass SHALL need a new `start`.

Structure
REQ-029 A shared package SHALL hold the state encoding, the AMP_W=12, PHASE_W=12 and ADDR_W=8 widths, and the 181 (0.707, Q0.8) threshold constant.
REQ-030 The block SHALL be one module with no sub-modules; the threshold multiply SHALL be a single registered product.

Verification
REQ-031 Scenario: table amp[i]=100+i, `tx_ready`=1, one `start` -> `peak_amp`=132, `peak_idx`=32, thr=93, `cut_*_found`=0, `done` on cycle 101 after `start`.
REQ-032 Scenario: band-pass table with amp=1000 at i=16, amp=800 at i=14..18, amp=300 elsewhere:
  - `peak_idx`=16, thr=707;
  - `cut_lo_idx`=13 and `cut_hi_idx`=19, both found flags 1.
REQ-033 Scenario: `tx_ready` toggling 1-in-3 cycles -> all 33 entries streamed in order with indices 0..32, `tx_*` stable while `tx_valid`=1 and `tx_ready`=0, no duplicates.
REQ-034 Scenario: equal peaks of 500 at i=5 and i=20 -> `peak_idx`=5.
REQ-035 Scenario: `start` pulsed during SEND -> ignored, only one `done`.
REQ-036 Scenario: `rst` pulsed at entry 10 -> all outputs 0 immediately, no `done`; a new `start` then completes normally.

Source files
------------

// File: rtl/sweep_result_reader_pkg.sv
// Shared definitions for the sweep result reader: datapath widths,
// controller state encoding and the -3 dB threshold scaling.
package sweep_result_reader_pkg;

  localparam int AMP_W    = 12;
  localparam int PHASE_W  = 12;
  localparam int ADDR_W   = 8;

  // 0.707 expressed in Q0.8, so the threshold is (peak * 181) >> 8
  localparam int THR_FRAC = 8;
  localparam logic [THR_FRAC-1:0] THR_COEF = 8'd181;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOAD,
    SEND,
    DONE
  } state_t;

  // Scale a peak amplitude down to its -3 dB threshold; the full 20-bit
  // product is formed and the fractional bits are dropped.
  function automatic logic [AMP_W-1:0] scale_thr(input logic [AMP_W-1:0] peak);
    logic [AMP_W+THR_FRAC-1:0] prod;
    prod = peak * THR_COEF;
    return prod[AMP_W+THR_FRAC-1:THR_FRAC];
  endfunction

endpackage

// File: rtl/sweep_result_reader.sv
// Sweep result reader: scans a combinational sweep table once to find the
// peak amplitude, then streams every entry over a valid/ready port while
// locating the lower and upper -3 dB cutoff indices.
module sweep_result_reader
  import sweep_result_reader_pkg::*;
#(
  parameter int N_POINTS = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [AMP_W-1:0]   amp_in,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [ADDR_W-1:0]  tx_index,
  output logic [AMP_W-1:0]   tx_amp,
  output logic [PHASE_W-1:0] tx_phase,
  output logic               busy,
  output logic               done,
  output logic [AMP_W-1:0]   peak_amp,
  output logic [ADDR_W-1:0]  peak_idx,
  output logic [ADDR_W-1:0]  cut_lo_idx,
  output logic [ADDR_W-1:0]  cut_hi_idx,
  output logic               cut_lo_found,
  output logic               cut_hi_found
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  state_t state;
  state_t state_next;

  logic [AMP_W-1:0]  thr;
  logic              scan_last;
  logic              send_last;
  logic              new_peak;
  logic [AMP_W-1:0]  peak_amp_next;
  logic [ADDR_W-1:0] peak_idx_next;
  logic              below_thr;

  assign scan_last     = (raddr == LAST_IDX);
  assign send_last     = (tx_index == LAST_IDX);
  // Strict compare so that equal amplitudes keep the earliest index
  assign new_peak      = (amp_in > peak_amp);
  assign peak_amp_next = new_peak ? amp_in : peak_amp;
  assign peak_idx_next = new_peak ? raddr : peak_idx;
  assign below_thr     = (tx_amp < thr);

  // State register, cleared asynchronously so a pass can be aborted at any time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; start is only honoured from IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (scan_last) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (tx_ready) state_next = send_last ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: peak search, threshold product, entry staging and cutoff capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr        <= '0;
      tx_valid     <= 1'b0;
      tx_index     <= '0;
      tx_amp       <= '0;
      tx_phase     <= '0;
      peak_amp     <= '0;
      peak_idx     <= '0;
      thr          <= '0;
      cut_lo_idx   <= '0;
      cut_hi_idx   <= '0;
      cut_lo_found <= 1'b0;
      cut_hi_found <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            raddr        <= '0;
            peak_amp     <= '0;
            peak_idx     <= '0;
            thr          <= '0;
            cut_lo_idx   <= '0;
            cut_hi_idx   <= '0;
            cut_lo_found <= 1'b0;
            cut_hi_found <= 1'b0;
          end
        end
        SCAN: begin
          peak_amp <= peak_amp_next;
          peak_idx <= peak_idx_next;
          if (scan_last) begin
            raddr <= '0;
            thr   <= scale_thr(peak_amp_next);
          end else begin
            raddr <= raddr + 1'b1;
          end
        end
        LOAD: begin
          tx_index <= raddr;
          tx_amp   <= amp_in;
          tx_phase <= phase_in;
          tx_valid <= 1'b1;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (below_thr) begin
              if (tx_index < peak_idx) begin
                cut_lo_idx   <= tx_index;
                cut_lo_found <= 1'b1;
              end else if ((tx_index > peak_idx) && !cut_hi_found) begin
                cut_hi_idx   <= tx_index;
                cut_hi_found <= 1'b1;
              end
            end
            if (!send_last) raddr <= raddr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_result_reader.sv
// Self-checking bench for sweep_result_reader: drives a behavioural sweep
// table, runs directed and randomised passes, and compares streamed entries,
// peak and cutoff results against a loop-based reference model.
module tb_sweep_result_reader;

  localparam int N = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  raddr;
  logic [11:0] amp_in;
  logic [11:0] phase_in;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_index;
  logic [11:0] tx_amp;
  logic [11:0] tx_phase;
  logic        busy;
  logic        done;
  logic [11:0] peak_amp;
  logic [7:0]  peak_idx;
  logic [7:0]  cut_lo_idx;
  logic [7:0]  cut_hi_idx;
  logic        cut_lo_found;
  logic        cut_hi_found;

  logic [11:0] amp_tab   [N];
  logic [11:0] phase_tab [N];
  logic [31:0] got_q [$];

  int n_compared   = 0;
  int n_mismatched = 0;

  int exp_peak, exp_idx, exp_lo, exp_hi, exp_lo_found, exp_hi_found;
  int latency, done_count;

  sweep_result_reader #(.N_POINTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .raddr        (raddr),
    .amp_in       (amp_in),
    .phase_in     (phase_in),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_index     (tx_index),
    .tx_amp       (tx_amp),
    .tx_phase     (tx_phase),
    .busy         (busy),
    .done         (done),
    .peak_amp     (peak_amp),
    .peak_idx     (peak_idx),
    .cut_lo_idx   (cut_lo_idx),
    .cut_hi_idx   (cut_hi_idx),
    .cut_lo_found (cut_lo_found),
    .cut_hi_found (cut_hi_found)
  );

  always #5 clk = ~clk;

  // Combinational sweep table read
  always_comb begin
    amp_in   = '0;
    phase_in = '0;
    if (int'(raddr) < N) begin
      amp_in   = amp_tab[int'(raddr)];
      phase_in = phase_tab[int'(raddr)];
    end
  end

  // Hard stop in case something hangs outside the bounded loops
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: peak, threshold and cutoffs straight from the table
  task automatic computeModel();
    int thr_v;
    exp_peak = 0; exp_idx = 0;
    for (int i = 0; i < N; i++)
      if (int'(amp_tab[i]) > exp_peak) begin exp_peak = int'(amp_tab[i]); exp_idx = i; end
    thr_v = (exp_peak * 181) / 256;
    exp_lo = 0; exp_lo_found = 0; exp_hi = 0; exp_hi_found = 0;
    for (int i = 0; i < exp_idx; i++)
      if (int'(amp_tab[i]) < thr_v) begin exp_lo = i; exp_lo_found = 1; end
    for (int i = N - 1; i > exp_idx; i--)
      if (int'(amp_tab[i]) < thr_v) begin exp_hi = i; exp_hi_found = 1; end
  endtask

  // Run one pass. ready_mode: 0 always ready, 1 ready 1-in-3, 2 random.
  task automatic applyStimulus(input int ready_mode, input bit poke_start);
    int cyc;
    bit stalled;
    logic [32:0] held;
    got_q.delete();
    latency = -1; done_count = 0; stalled = 1'b0; held = '0;
    tx_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc < 1500) begin
      if (done) begin
        done_count++;
        if (latency < 0) latency = cyc;
      end
      if (latency >= 0 && cyc >= latency + 4) break;
      if (stalled)
        checkOutput("stall_hold", {31'd0, tx_valid, tx_index, tx_amp, tx_phase},
                    {31'd0, held});
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && tx_ready) got_q.push_back({tx_index, tx_amp, tx_phase});
      stalled = tx_valid && !tx_ready;
      held    = {tx_valid, tx_index, tx_amp, tx_phase};
      start   = poke_start && (cyc == 40);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tx_ready = 1'b0;
    checkOutput("done_seen", 64'(latency >= 0), 64'd1);
  endtask

  // Compare the finished pass against the reference model
  task automatic checkPass(input string name);
    computeModel();
    checkOutput({name, "_count"}, 64'(got_q.size()), 64'(N));
    for (int i = 0; i < N && i < got_q.size(); i++)
      checkOutput($sformatf("%s_entry%0d", name, i), 64'(got_q[i]),
                  64'({8'(i), amp_tab[i], phase_tab[i]}));
    checkOutput({name, "_done_once"}, 64'(done_count), 64'd1);
    checkOutput({name, "_peak_amp"}, 64'(peak_amp), 64'(exp_peak));
    checkOutput({name, "_peak_idx"}, 64'(peak_idx), 64'(exp_idx));
    checkOutput({name, "_cut_lo"}, 64'({cut_lo_found, cut_lo_idx}),
                64'({1'(exp_lo_found), 8'(exp_lo)}));
    checkOutput({name, "_cut_hi"}, 64'({cut_hi_found, cut_hi_idx}),
                64'({1'(exp_hi_found), 8'(exp_hi)}));
    checkOutput({name, "_idle"}, 64'({busy, done, tx_valid, tx_index}),
                64'({3'b000, 8'(N - 1)}));
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_port_a"},
                64'({raddr, tx_valid, tx_index, tx_amp, tx_phase, busy, done}), 64'd0);
    checkOutput({name, "_port_b"},
                64'({peak_amp, peak_idx, cut_lo_idx, cut_hi_idx, cut_lo_found, cut_hi_found}),
                64'd0);
  endtask

  initial begin
    int found10;
    for (int i = 0; i < N; i++) begin
      amp_tab[i]   = 12'(100 + i);
      phase_tab[i] = 12'($urandom_range(0, 3216) - 1608);
    end

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Rising ramp, always ready: latency and directed peak values
    $display("[TB] ramp table, ready held high");
    applyStimulus(0, 1'b0);
    // start-sampling edge through the edge entering DONE: 3N+1 edges, i.e.
    // done in the 101st cycle counting the start cycle as the first
    checkOutput("ramp_latency", 64'(latency), 64'(3 * N + 1));
    checkOutput("ramp_peak_direct", 64'({peak_amp, peak_idx}), 64'({12'd132, 8'd32}));
    checkOutput("ramp_no_cut", 64'({cut_lo_found, cut_hi_found}), 64'd0);
    checkPass("ramp");
    repeat (5) @(negedge clk);
    checkOutput("ramp_hold_in_idle", 64'({peak_amp, peak_idx, tx_amp}),
                64'({12'd132, 8'd32, 12'd132}));

    // Band-pass table, random ready
    $display("[TB] band-pass table, random ready");
    for (int i = 0; i < N; i++) amp_tab[i] = (i >= 14 && i <= 18) ? 12'd800 : 12'd300;
    amp_tab[16] = 12'd1000;
    applyStimulus(2, 1'b0);
    checkOutput("band_direct",
                64'({peak_idx, cut_lo_idx, cut_hi_idx, cut_lo_found, cut_hi_found}),
                64'({8'd16, 8'd13, 8'd19, 2'b11}));
    checkPass("band");

    // Random table, ready 1-in-3
    $display("[TB] random table, ready 1-in-3");
    for (int i = 0; i < N; i++) begin
      amp_tab[i]   = 12'($urandom_range(0, 4095));
      phase_tab[i] = 12'($urandom_range(0, 3216) - 1608);
    end
    applyStimulus(1, 1'b0);
    checkPass("rand3");

    // Equal peaks: lowest index must win
    $display("[TB] equal peaks at 5 and 20");
    for (int i = 0; i < N; i++) amp_tab[i] = 12'($urandom_range(0, 499));
    amp_tab[5]  = 12'd500;
    amp_tab[20] = 12'd500;
    applyStimulus(2, 1'b0);
    checkOutput("tie_direct", 64'({peak_amp, peak_idx}), 64'({12'd500, 8'd5}));
    checkPass("tie");

    // start pulsed mid-stream must be ignored
    $display("[TB] start pulsed during SEND");
    for (int i = 0; i < N; i++) amp_tab[i] = 12'($urandom_range(0, 4095));
    applyStimulus(0, 1'b1);
    checkPass("poke");
    repeat (3) @(negedge clk);
    checkOutput("poke_stays_idle", 64'(busy), 64'd0);

    // All-zero table
    $display("[TB] all-zero table");
    for (int i = 0; i < N; i++) amp_tab[i] = 12'd0;
    applyStimulus(2, 1'b0);
    checkOutput("zero_direct",
                64'({peak_amp, peak_idx, cut_lo_found, cut_hi_found}), 64'd0);
    checkPass("zero");

    // Reset while entry 10 is on the port
    $display("[TB] reset mid-pass");
    for (int i = 0; i < N; i++) amp_tab[i] = 12'($urandom_range(1, 4095));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tx_ready = 1'b1;
    found10 = 0;
    for (int k = 0; k < 200 && found10 == 0; k++) begin
      if (tx_valid && tx_index == 8'd10) found10 = 1;
      else @(negedge clk);
    end
    checkOutput("rst_reach_entry10", 64'(found10), 64'd1);
    rst = 1'b1;
    #1;
    checkAllZero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    done_count = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_count++;
    end
    checkOutput("rst_no_restart", 64'(done_count), 64'd0);
    tx_ready = 1'b0;
    applyStimulus(0, 1'b0);
    checkPass("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
